// File: rtl/nibble_add_pkg.sv
// Shared types and helpers for the nibble-serial adder controller.
// The optional subtract mode is enabled by defining NIBBLE_ADD_SUB_EN.
package nibble_add_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed to count 0..n-1 (at least 1).
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/nibble_add4.sv
// Purely combinational 4-bit ripple-carry slice built from 1-bit full adders.
module nibble_add4
    import nibble_add_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             ci,
    output logic [NIB_W-1:0] s,
    output logic             co
);

    logic [NIB_W:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < NIB_W; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end

    assign co = c[NIB_W];

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Adds two WIDTH-bit operands by sequencing one shared 4-bit slice over WIDTH/4 cycles.
// Define NIBBLE_ADD_SUB_EN to add the sub_i port (A-B, cout_o=1 means no borrow).
module nibble_serial_add_ctrl
    import nibble_add_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
`ifdef NIBBLE_ADD_SUB_EN
    input  logic             sub_i,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             busy_o,
    output logic [1:0]       state_o
);

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // in_ready is high only in IDLE; out_valid holds with stable data until out_ready.

    localparam int NIBBLES = WIDTH / NIB_W;
    localparam int CW      = clog2(NIBBLES);
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    state_t                   state;
    logic [WIDTH-1:0]         a_sh;
    logic [WIDTH-1:0]         b_sh;
    logic [WIDTH-NIB_W-1:0]   sum_sh;
    logic                     carry;
    logic [CW-1:0]            cnt;

    logic [NIB_W-1:0]         slice_s;
    logic                     slice_co;
    logic [WIDTH-1:0]         sum_next;

    nibble_add4 u_slice (
        .a  (a_sh[NIB_W-1:0]),
        .b  (b_sh[NIB_W-1:0]),
        .ci (carry),
        .s  (slice_s),
        .co (slice_co)
    );

    // New nibble lands on top; the lowest stored nibble drops into the final word.
    assign sum_next = {slice_s, sum_sh};
    assign in_ready = (state == IDLE);
    assign state_o  = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            sum_sh    <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            sum_o     <= '0;
            cout_o    <= 1'b0;
            out_valid <= 1'b0;
            busy_o    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh   <= a_i;
`ifdef NIBBLE_ADD_SUB_EN
                        b_sh   <= sub_i ? ~b_i : b_i;
                        carry  <= sub_i ? 1'b1 : cin_i;
`else
                        b_sh   <= b_i;
                        carry  <= cin_i;
`endif
                        cnt    <= '0;
                        busy_o <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> NIB_W;
                    b_sh   <= b_sh >> NIB_W;
                    sum_sh <= sum_next[WIDTH-1:NIB_W];
                    carry  <= slice_co;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        sum_o     <= sum_next;
                        cout_o    <= slice_co;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy_o    <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    busy_o    <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Randomized self-checking bench for nibble_serial_add_ctrl against an arithmetic model.
// Subtract checks are included when NIBBLE_ADD_SUB_EN is defined.
module tb_nibble_serial_add_ctrl;

    localparam int WIDTH   = 16;
    localparam int NIBBLES = WIDTH / 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             cin_i;
    logic             sub_i;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum_o;
    logic             cout_o;
    logic             busy_o;
    logic [1:0]       state_o;

    int total;
    int bad;

    logic [WIDTH:0] exp_q[$];

    nibble_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_i       (a_i),
        .b_i       (b_i),
        .cin_i     (cin_i),
`ifdef NIBBLE_ADD_SUB_EN
        .sub_i     (sub_i),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum_o     (sum_o),
        .cout_o    (cout_o),
        .busy_o    (busy_o),
        .state_o   (state_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic, {cout, sum}.
    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic cin, input logic sub);
        longint unsigned r;
        if (sub) begin
            r = (longint'(a) - longint'(b)) & ((64'd1 << WIDTH) - 1);
            return {(a >= b) ? 1'b1 : 1'b0, r[WIDTH-1:0]};
        end
        r = longint'(a) + longint'(b) + longint'(cin);
        return r[WIDTH:0];
    endfunction

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_i       = '0;
        b_i       = '0;
        cin_i     = 1'b0;
        sub_i     = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // One full operation: accept, wait for result, optionally stall, then hand off.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin,
                          input logic sub, input int hold, input bit toggle);
        logic [WIDTH:0] exp;
        int lat;
        a_i      = a;
        b_i      = b;
        cin_i    = cin;
        sub_i    = sub;
        in_valid = 1'b1;
        check("in_ready_idle", in_ready, 1);
        exp_q.push_back(model(a, b, cin, sub));
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            check("in_ready_run", in_ready, 0);
            check("busy_run", busy_o, 1);
            if (toggle) begin
                in_valid = 1'($urandom_range(0, 1));
                a_i      = WIDTH'($urandom);
                b_i      = WIDTH'($urandom);
                cin_i    = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        check("latency", lat, NIBBLES);
        check("out_valid_done", out_valid, 1);
        exp = exp_q.pop_front();
        check("sum", sum_o, exp[WIDTH-1:0]);
        check("cout", cout_o, exp[WIDTH]);
        for (int i = 0; i < hold; i++) begin
            out_ready = 1'b0;
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_sum", sum_o, exp[WIDTH-1:0]);
            check("hold_cout", cout_o, exp[WIDTH]);
            check("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("post_valid", out_valid, 0);
        check("post_in_ready", in_ready, 1);
        check("post_busy", busy_o, 0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        do_reset();

        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum_o, 0);
        check("rst_cout", cout_o, 0);
        check("rst_busy", busy_o, 0);

        run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
        run_op(16'h1234, 16'h4321, 1'b1, 1'b0, 0, 1'b1);
        run_op(16'h0000, 16'h0000, 1'b1, 1'b0, 5, 1'b0);
        run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1, 1'b0);

        // Abort mid-RUN: accept, two RUN edges, then reset.
        a_i      = 16'hABCD;
        b_i      = 16'h1111;
        cin_i    = 1'b0;
        sub_i    = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_sum", sum_o, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_busy", busy_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 0, 1'b0);

`ifdef NIBBLE_ADD_SUB_EN
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0, 1'b0);
        run_op(16'h0007, 16'h0005, 1'b1, 1'b1, 0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)), 1'b1,
                   $urandom_range(0, 2), 1'b0);
        end
`endif

        for (int i = 0; i < 25; i++) begin
            run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)), 1'b0,
                   $urandom_range(0, 3), bit'($urandom_range(0, 1)));
        end

        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
